seq_divider: RTL and testbench



---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 26 ++
 rtl/seq_divider.sv | 163 ++++++++++++++++
 tb/tb_seq_divider.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// widths (matching the 5x5 multiplier), FSM state encoding, the
// divide-by-zero quotient constant and the iteration counter width.
package div_pkg;

  localparam int DEF_DIVIDEND_W = 10;
  localparam int DEF_DIVISOR_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // All ones; truncated by the user to the quotient width.
  localparam logic [31:0] DBZ_QUOTIENT = '1;

  // Counter must hold 0..dividend_w.
  function automatic int div_cnt_w(input int dividend_w);
    return $clog2(dividend_w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor if it fits.
module div_step #(
  parameter int DIVISOR_W = 5
) (
  input  logic [DIVISOR_W-1:0] rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  // partial keeps the extra MSB so the compare never truncates.
  logic [DIVISOR_W:0]   partial;
  logic [DIVISOR_W-1:0] diff;

  // Trial subtraction; when it fits the true difference is < divisor,
  // so the low DIVISOR_W bits of the modular subtraction are exact.
  always_comb begin
    partial = {rem_in, bit_in};
    diff    = partial[DIVISOR_W-1:0] - divisor;
    q_bit   = (partial >= {1'b0, divisor});
    rem_out = q_bit ? diff : partial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands,
// quotient truncated toward zero, remainder takes the dividend's sign).
//
// Handshake: a request is accepted on a rising edge where start=1 and
// ready=1 (IDLE or DONE). start while busy is ignored. done pulses for one
// cycle when results land; quotient/remainder/div_by_zero then hold until
// the next completion (div_by_zero clears at accept).
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = div_cnt_w(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] DBZ_Q    = DIVIDEND_W'(DBZ_QUOTIENT);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  div_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  // dvd_q shifts dividend bits out at the top and quotient bits in at the bottom.
  logic [DIVIDEND_W-1:0]  dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]   dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]   rem_q, rem_d;
  logic [DIVIDEND_W-1:0]  quo_q, quo_d;
  logic [DIVISOR_W-1:0]   rmd_q, rmd_d;
  logic                   dbz_q, dbz_d;
  logic                   done_q, done_d;
`ifdef DIV_SIGNED_EN
  logic                   qneg_q, qneg_d;
  logic                   rneg_q, rneg_d;
`endif

  logic [DIVISOR_W-1:0]   step_rem;
  logic                   step_q;
  logic [DIVIDEND_W-1:0]  q_next;

  div_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign q_next = {dvd_q[DIVIDEND_W-2:0], step_q};

  // State register and datapath registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
`ifdef DIV_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  // Next-state logic: accept, iterate, and publish results on DONE entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
`ifdef DIV_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
`ifdef DIV_SIGNED_EN
          dvd_d  = dividend[DIVIDEND_W-1] ? -dividend : dividend;
          dvs_d  = divisor[DIVISOR_W-1] ? -divisor : divisor;
          qneg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          rneg_d = dividend[DIVIDEND_W-1];
`else
          dvd_d  = dividend;
          dvs_d  = divisor;
`endif
          rem_d  = '0;
          cnt_d  = '0;
          dbz_d  = 1'b0;
          if (divisor == '0) begin
            // No iteration needed: results are fixed constants.
            state_d = DONE;
            done_d  = 1'b1;
            quo_d   = DBZ_Q;
            rmd_d   = '0;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = q_next;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          done_d  = 1'b1;
`ifdef DIV_SIGNED_EN
          quo_d   = qneg_q ? -q_next : q_next;
          rmd_d   = rneg_q ? -step_rem : step_rem;
`else
          quo_d   = q_next;
          rmd_d   = step_rem;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready       = (state_q == IDLE) || (state_q == DONE);
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, hand-written multi-cycle
// sequences (held start, back-to-back, mid-run reset) and random operands
// checked against an arithmetic reference model. Honours DIV_SIGNED_EN.
module tb_seq_divider;

  logic       clock;
  logic       reset_n;
  logic       start_r;
  logic [9:0] dividend_r;
  logic [4:0] divisor_r;
  logic       ready_w, busy_w, done_w, dbz_w;
  logic [9:0] quotient_w;
  logic [4:0] remainder_w;

  int checks = 0;
  int errors = 0;

  // Expected results {div_by_zero, remainder, quotient}, oldest first.
  logic [15:0] exp_q[$];

  typedef struct {
    logic [9:0] a;
    logic [4:0] b;
    logic [9:0] q;
    logic [4:0] r;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  seq_divider dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start_r),
    .dividend    (dividend_r),
    .divisor     (divisor_r),
    .ready       (ready_w),
    .busy        (busy_w),
    .done        (done_w),
    .quotient    (quotient_w),
    .remainder   (remainder_w),
    .div_by_zero (dbz_w)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference model from plain arithmetic.
  function automatic logic [15:0] model(input logic [9:0] a, input logic [4:0] b);
    int qa, ra;
    logic [9:0] q;
    logic [4:0] r;
    if (b == 5'd0) return {1'b1, 5'd0, 10'h3FF};
`ifdef DIV_SIGNED_EN
    qa = int'($signed(a)) / int'($signed(b));
    ra = int'($signed(a)) % int'($signed(b));
`else
    qa = int'(a) / int'(b);
    ra = int'(a) % int'(b);
`endif
    q = qa[9:0];
    r = ra[4:0];
    return {1'b0, r, q};
  endfunction

  function automatic vec_t mk(input logic [9:0] a, input logic [4:0] b, input logic [9:0] q,
                              input logic [4:0] r, input logic dbz, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dbz = dbz; v.lat = lat;
    return v;
  endfunction

  // Wait (bounded) for done after an accept; lat counts edges with the
  // accept edge as 1, busy_cnt counts cycles observed with busy=1.
  task automatic wait_done(inout int lat, inout int busy_cnt);
    while (!done_w && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (busy_w) busy_cnt++;
    end
  endtask

  task automatic compare_result(input string tag, input int lat, input int busy_cnt, input int exp_lat);
    logic [15:0] want;
    want = exp_q.pop_front();
    check({tag, "_done"},      32'(done_w),      32'd1);
    check({tag, "_quotient"},  32'(quotient_w),  32'(want[9:0]));
    check({tag, "_remainder"}, 32'(remainder_w), 32'(want[14:10]));
    check({tag, "_dbz"},       32'(dbz_w),       32'(want[15]));
    check({tag, "_latency"},   32'(lat),         32'(exp_lat));
    check({tag, "_busy_cyc"},  32'(busy_cnt),    32'(exp_lat - 1));
  endtask

  // Drive one operation and check result, latency and the one-cycle done pulse.
  task automatic run_op(input logic [9:0] a, input logic [4:0] b, input logic [15:0] exp,
                        input int exp_lat, input string tag);
    int lat, busy_cnt;
    exp_q.push_back(exp);
    @(negedge clock);
    dividend_r = a; divisor_r = b; start_r = 1'b1;
    @(posedge clock); #1;
    start_r  = 1'b0;
    lat      = 1;
    busy_cnt = busy_w ? 1 : 0;
    if (busy_w) check({tag, "_ready_in_run"}, 32'(ready_w), 32'd0);
    wait_done(lat, busy_cnt);
    compare_result(tag, lat, busy_cnt, exp_lat);
    @(posedge clock); #1;
    check({tag, "_done_drop"},  32'(done_w),     32'd0);
    check({tag, "_ready_hold"}, 32'(ready_w),    32'd1);
    check({tag, "_q_hold"},     32'(quotient_w), 32'(exp[9:0]));
  endtask

  initial begin
    int lat, busy_cnt;
    logic [9:0] ra;
    logic [4:0] rb;

    // Clock/reset block.
    reset_n = 1'b0; start_r = 1'b0; dividend_r = '0; divisor_r = '0;
    #12;
    check("rst_ready",     32'(ready_w),     32'd1);
    check("rst_busy",      32'(busy_w),      32'd0);
    check("rst_done",      32'(done_w),      32'd0);
    check("rst_quotient",  32'(quotient_w),  32'd0);
    check("rst_remainder", 32'(remainder_w), 32'd0);
    check("rst_dbz",       32'(dbz_w),       32'd0);
    @(negedge clock); reset_n = 1'b1;

    // Directed vector table.
`ifdef DIV_SIGNED_EN
    vecs.push_back(mk(10'd24,  5'd8,  10'd3,   5'd0,  1'b0, 11));
    vecs.push_back(mk(10'h3E8, 5'd8,  10'h3FD, 5'd0,  1'b0, 11)); // -24/8
    vecs.push_back(mk(10'h3E7, 5'd4,  10'h3FA, 5'h1F, 1'b0, 11)); // -25/4
    vecs.push_back(mk(10'd25,  5'h1C, 10'h3FA, 5'd1,  1'b0, 11)); // 25/-4
    vecs.push_back(mk(10'h200, 5'h1F, 10'h200, 5'd0,  1'b0, 11)); // -512/-1
    vecs.push_back(mk(10'd20,  5'd0,  10'h3FF, 5'd0,  1'b1, 1));
    vecs.push_back(mk(10'd24,  5'd8,  10'd3,   5'd0,  1'b0, 11));
`else
    vecs.push_back(mk(10'd24,   5'd8,  10'd3,   5'd0, 1'b0, 11));
    vecs.push_back(mk(10'd400,  5'd16, 10'd25,  5'd0, 1'b0, 11));
    vecs.push_back(mk(10'd1023, 5'd31, 10'd33,  5'd0, 1'b0, 11));
    vecs.push_back(mk(10'd31,   5'd1,  10'd31,  5'd0, 1'b0, 11));
    vecs.push_back(mk(10'd0,    5'd20, 10'd0,   5'd0, 1'b0, 11));
    vecs.push_back(mk(10'd1000, 5'd7,  10'd142, 5'd6, 1'b0, 11));
    vecs.push_back(mk(10'd20,   5'd0,  10'h3FF, 5'd0, 1'b1, 1));
    vecs.push_back(mk(10'd24,   5'd8,  10'd3,   5'd0, 1'b0, 11));
`endif
    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i].a, vecs[i].b, {vecs[i].dbz, vecs[i].r, vecs[i].q}, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    // start held high while busy with other operands, then back-to-back.
    exp_q.push_back({1'b0, 5'd0, 10'd3});
    @(negedge clock);
    dividend_r = 10'd24; divisor_r = 5'd8; start_r = 1'b1;
    @(posedge clock); #1;
    dividend_r = 10'd5; divisor_r = 5'd1;
    lat = 1; busy_cnt = busy_w ? 1 : 0;
    wait_done(lat, busy_cnt);
    compare_result("held", lat, busy_cnt, 11);
    exp_q.push_back({1'b0, 5'd0, 10'd5});
    @(posedge clock); #1;
    start_r = 1'b0;
    check("b2b_accept_busy", 32'(busy_w), 32'd1);
    check("b2b_q_kept_in_run", 32'(quotient_w), 32'd3);
    lat = 1; busy_cnt = busy_w ? 1 : 0;
    wait_done(lat, busy_cnt);
    compare_result("b2b", lat, busy_cnt, 11);

    // Reset mid-run at count=4 (accept edge plus four run edges).
    @(negedge clock);
    dividend_r = 10'd500; divisor_r = 5'd3; start_r = 1'b1;
    @(posedge clock); #1;
    start_r = 1'b0;
    repeat (4) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_ready",     32'(ready_w),     32'd1);
    check("midrst_busy",      32'(busy_w),      32'd0);
    check("midrst_done",      32'(done_w),      32'd0);
    check("midrst_quotient",  32'(quotient_w),  32'd0);
    check("midrst_remainder", 32'(remainder_w), 32'd0);
    check("midrst_dbz",       32'(dbz_w),       32'd0);
    @(negedge clock); reset_n = 1'b1;
    run_op(10'd100, 5'd9, {1'b0, 5'd1, 10'd11}, 11, "after_rst");

    // Random operands against the reference model.
    for (int n = 0; n < 40; n++) begin
      ra = 10'($urandom_range(0, 1023));
      rb = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_op(ra, rb, model(ra, rb), (rb == 5'd0) ? 1 : 11, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
